// File: rtl/synth_slot_scheduler_if.sv
// Frame-trigger inputs and slot-timing outputs of synth_slot_scheduler.
// Optional macro SLOT_OVERRUN_CNT_EN adds the 8-bit overrun_cnt signal.
interface synth_slot_scheduler_if #(
    parameter int PARTS   = 2,
    parameter int P_WIDTH = 1,
    parameter int V_WIDTH = 5,
    parameter int E_WIDTH = 4,
    parameter int C_WIDTH = 2
);
    logic                               trig;
    logic [PARTS-1:0]                   part_mask;
    logic                               overrun_clr;
    logic                               run;
    logic [P_WIDTH+V_WIDTH+E_WIDTH-1:0] xxxx;
    logic [C_WIDTH-1:0]                 slot_phase;
    logic                               sCLK_XVXENVS;
    logic                               sCLK_XVXOSC;
    logic                               xxxx_zero;
    logic                               frame_done;
    logic                               overrun;
`ifdef SLOT_OVERRUN_CNT_EN
    logic [7:0]                         overrun_cnt;

    modport master (
        output trig, part_mask, overrun_clr,
        input  run, xxxx, slot_phase, sCLK_XVXENVS, sCLK_XVXOSC,
        input  xxxx_zero, frame_done, overrun, overrun_cnt
    );
    modport slave (
        input  trig, part_mask, overrun_clr,
        output run, xxxx, slot_phase, sCLK_XVXENVS, sCLK_XVXOSC,
        output xxxx_zero, frame_done, overrun, overrun_cnt
    );
`else
    modport master (
        output trig, part_mask, overrun_clr,
        input  run, xxxx, slot_phase, sCLK_XVXENVS, sCLK_XVXOSC,
        input  xxxx_zero, frame_done, overrun
    );
    modport slave (
        input  trig, part_mask, overrun_clr,
        output run, xxxx, slot_phase, sCLK_XVXENVS, sCLK_XVXOSC,
        output xxxx_zero, frame_done, overrun
    );
`endif
endinterface

// File: rtl/synth_slot_scheduler.sv
// Sweeps every {part, voice, osc, env} slot once per audio frame and emits slot strobes.
// Optional macro SLOT_OVERRUN_CNT_EN adds a saturating 8-bit overrun event counter.
module synth_slot_scheduler #(
    parameter int VOICES       = 32,
    parameter int V_OSC        = 8,
    parameter int O_ENVS       = 2,
    parameter int PARTS        = 2,
    parameter int CYC_PER_SLOT = 4,
    parameter int V_WIDTH      = $clog2(VOICES),
    parameter int E_WIDTH      = $clog2(V_OSC) + $clog2(O_ENVS),
    parameter int P_WIDTH      = (PARTS > 1) ? $clog2(PARTS) : 1,
    parameter int C_WIDTH      = (CYC_PER_SLOT > 1) ? $clog2(CYC_PER_SLOT) : 1
) (
    input  logic                  AUDIO_CLK,
    input  logic                  reset_data_N,
    synth_slot_scheduler_if.slave bus
);
    localparam int VE_WIDTH = V_WIDTH + E_WIDTH;
    localparam logic [VE_WIDTH-1:0] VE_LAST    = {VE_WIDTH{1'b1}};
    localparam logic [VE_WIDTH-1:0] ENV_MASK   = VE_WIDTH'(O_ENVS - 1);
    localparam logic [C_WIDTH-1:0]  PHASE_LAST = C_WIDTH'(CYC_PER_SLOT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns {found, index} of the lowest set bit of mask.
    function automatic logic [P_WIDTH:0] lowest_part(input logic [PARTS-1:0] mask);
        logic [P_WIDTH:0] r;
        r = {(P_WIDTH+1){1'b0}};
        for (int i = PARTS - 1; i >= 0; i--) begin
            if (mask[i]) r = {1'b1, P_WIDTH'(i)};
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit of mask strictly above cur.
    function automatic logic [P_WIDTH:0] next_part(input logic [PARTS-1:0] mask,
                                                   input logic [P_WIDTH-1:0] cur);
        logic [P_WIDTH:0] r;
        r = {(P_WIDTH+1){1'b0}};
        for (int i = PARTS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) r = {1'b1, P_WIDTH'(i)};
        end
        return r;
    endfunction

    state_t                state_r;
    logic                  trig_q_r;
    logic                  trig_vld_r;
    logic [PARTS-1:0]      mask_r;
    logic [P_WIDTH-1:0]    part_r;
    logic [VE_WIDTH-1:0]   ve_r;
    logic [C_WIDTH-1:0]    phase_r;
    logic                  run_r;
    logic                  env_stb_r;
    logic                  osc_stb_r;
    logic                  zero_r;
    logic                  done_r;
    logic                  overrun_r;

    logic                  trig_edge_s;
    logic                  ovr_evt_s;
    logic [P_WIDTH:0]      first_s;
    logic [P_WIDTH:0]      next_s;
    logic [VE_WIDTH-1:0]   ve_inc_s;
    logic                  osc_next_s;

    // Edge detect, part selection and next-slot decode.
    always_comb begin
        trig_edge_s = bus.trig & ~trig_q_r & trig_vld_r;
        ovr_evt_s   = trig_edge_s & (state_r != ST_IDLE);
        first_s     = lowest_part(bus.part_mask);
        next_s      = next_part(mask_r, part_r);
        ve_inc_s    = ve_r + VE_WIDTH'(1'b1);
        osc_next_s  = ((ve_inc_s & ENV_MASK) == {VE_WIDTH{1'b0}});
    end

    // Trigger history; trig_vld_r masks the first clock so a level held through reset is not an edge.
    always_ff @(posedge AUDIO_CLK or negedge reset_data_N) begin
        if (!reset_data_N) begin
            trig_q_r   <= 1'b0;
            trig_vld_r <= 1'b0;
        end else begin
            trig_q_r   <= bus.trig;
            trig_vld_r <= 1'b1;
        end
    end

    // Frame sweep FSM with registered slot index and strobes.
    always_ff @(posedge AUDIO_CLK or negedge reset_data_N) begin
        if (!reset_data_N) begin
            state_r   <= ST_IDLE;
            mask_r    <= {PARTS{1'b0}};
            part_r    <= {P_WIDTH{1'b0}};
            ve_r      <= {VE_WIDTH{1'b0}};
            phase_r   <= {C_WIDTH{1'b0}};
            run_r     <= 1'b0;
            env_stb_r <= 1'b0;
            osc_stb_r <= 1'b0;
            zero_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (trig_edge_s) begin
                        mask_r <= bus.part_mask;
                        if (first_s[P_WIDTH]) begin
                            state_r   <= ST_SWEEP;
                            run_r     <= 1'b1;
                            part_r    <= first_s[P_WIDTH-1:0];
                            ve_r      <= {VE_WIDTH{1'b0}};
                            phase_r   <= {C_WIDTH{1'b0}};
                            env_stb_r <= 1'b1;
                            osc_stb_r <= 1'b1;
                            zero_r    <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    zero_r <= 1'b0;
                    if (phase_r != PHASE_LAST) begin
                        phase_r   <= phase_r + C_WIDTH'(1'b1);
                        env_stb_r <= 1'b0;
                        osc_stb_r <= 1'b0;
                    end else begin
                        phase_r <= {C_WIDTH{1'b0}};
                        if (ve_r != VE_LAST) begin
                            ve_r      <= ve_inc_s;
                            env_stb_r <= 1'b1;
                            osc_stb_r <= osc_next_s;
                        end else if (next_s[P_WIDTH]) begin
                            part_r    <= next_s[P_WIDTH-1:0];
                            ve_r      <= {VE_WIDTH{1'b0}};
                            env_stb_r <= 1'b1;
                            osc_stb_r <= 1'b1;
                        end else begin
                            state_r   <= ST_DONE;
                            run_r     <= 1'b0;
                            part_r    <= {P_WIDTH{1'b0}};
                            ve_r      <= {VE_WIDTH{1'b0}};
                            env_stb_r <= 1'b0;
                            osc_stb_r <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    run_r     <= 1'b0;
                    part_r    <= {P_WIDTH{1'b0}};
                    ve_r      <= {VE_WIDTH{1'b0}};
                    phase_r   <= {C_WIDTH{1'b0}};
                    env_stb_r <= 1'b0;
                    osc_stb_r <= 1'b0;
                    zero_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a fresh event outranks a clear.
    always_ff @(posedge AUDIO_CLK or negedge reset_data_N) begin
        if (!reset_data_N) begin
            overrun_r <= 1'b0;
        end else if (ovr_evt_s) begin
            overrun_r <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

`ifdef SLOT_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_r;

    // Saturating overrun event counter; clear outranks increment.
    always_ff @(posedge AUDIO_CLK or negedge reset_data_N) begin
        if (!reset_data_N) begin
            overrun_cnt_r <= 8'd0;
        end else if (bus.overrun_clr) begin
            overrun_cnt_r <= 8'd0;
        end else if (ovr_evt_s && (overrun_cnt_r != 8'd255)) begin
            overrun_cnt_r <= overrun_cnt_r + 8'd1;
        end else begin
            overrun_cnt_r <= overrun_cnt_r;
        end
    end

    assign bus.overrun_cnt = overrun_cnt_r;
`endif

    assign bus.run          = run_r;
    assign bus.xxxx         = {part_r, ve_r};
    assign bus.slot_phase   = phase_r;
    assign bus.sCLK_XVXENVS = env_stb_r;
    assign bus.sCLK_XVXOSC  = osc_stb_r;
    assign bus.xxxx_zero    = zero_r;
    assign bus.frame_done   = done_r;
    assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_synth_slot_scheduler.sv
// Directed bench for synth_slot_scheduler: 4 voices x 2 osc x 2 env x 2 parts, 4 cycles/slot.
module tb_synth_slot_scheduler;
    localparam int CYC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    int run_cnt, env_cnt, osc_cnt, zero_cnt, zero_x, first_x, last_x;
    int seq_err, phase_err, stray, done_tick, timed_out;

    synth_slot_scheduler_if #(.PARTS(2), .P_WIDTH(1), .V_WIDTH(2), .E_WIDTH(2), .C_WIDTH(2)) bus();

    synth_slot_scheduler #(
        .VOICES(4), .V_OSC(2), .O_ENVS(2), .PARTS(2), .CYC_PER_SLOT(CYC)
    ) dut (
        .AUDIO_CLK   (clk),
        .reset_data_N(rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame (trig already raised) and records its statistics; act_kind injects mid-frame events.
    task automatic capture_frame(input int act_cycle, input int act_kind);
        int exp_x;
        run_cnt = 0; env_cnt = 0; osc_cnt = 0; zero_cnt = 0; zero_x = -1;
        first_x = -1; last_x = -1; seq_err = 0; phase_err = 0; stray = 0;
        done_tick = 0; timed_out = 1; exp_x = 0;
        for (int t = 1; t <= 2000; t++) begin
            tick();
            if (bus.run === 1'b1) begin
                run_cnt++;
                if (int'(bus.slot_phase) != ((run_cnt - 1) % CYC)) phase_err++;
                if (bus.sCLK_XVXENVS === 1'b1) begin
                    env_cnt++;
                    if (first_x < 0) first_x = int'(bus.xxxx);
                    else if (int'(bus.xxxx) != exp_x) seq_err++;
                    exp_x  = int'(bus.xxxx) + 1;
                    last_x = int'(bus.xxxx);
                end
                if (bus.sCLK_XVXOSC === 1'b1) osc_cnt++;
                if (bus.xxxx_zero === 1'b1) begin
                    zero_cnt++;
                    zero_x = int'(bus.xxxx);
                end
                if (run_cnt == 1) bus.trig = 1'b0;
                if (act_kind == 1 && run_cnt == act_cycle) bus.trig = 1'b1;
                if (act_kind == 1 && run_cnt == act_cycle + 1) bus.trig = 1'b0;
                if (act_kind == 2 && run_cnt == act_cycle) bus.part_mask = 2'b01;
            end else if (bus.sCLK_XVXENVS !== 1'b0 || bus.sCLK_XVXOSC !== 1'b0 || bus.xxxx_zero !== 1'b0) begin
                stray++;
            end
            if (bus.frame_done === 1'b1) begin
                done_tick = t;
                timed_out = 0;
                if (bus.run !== 1'b0 || bus.xxxx !== 5'd0) stray++;
                if (act_kind == 3) bus.trig = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.trig = 1'b0; bus.part_mask = 2'b00; bus.overrun_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        cmp_cnt++; if ({bus.run, bus.sCLK_XVXENVS, bus.sCLK_XVXOSC, bus.xxxx_zero, bus.frame_done, bus.overrun} !== 6'b0) begin err_cnt++; $display("FAIL reset_flags: got %b expected 000000", {bus.run, bus.sCLK_XVXENVS, bus.sCLK_XVXOSC, bus.xxxx_zero, bus.frame_done, bus.overrun}); end
        cmp_cnt++; if (bus.xxxx !== 5'd0) begin err_cnt++; $display("FAIL reset_xxxx: got %0d expected 0", bus.xxxx); end
        cmp_cnt++; if (bus.slot_phase !== 2'd0) begin err_cnt++; $display("FAIL reset_phase: got %0d expected 0", bus.slot_phase); end
`ifdef SLOT_OVERRUN_CNT_EN
        cmp_cnt++; if (bus.overrun_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_ovr_cnt: got %0d expected 0", bus.overrun_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full_frame();
        bus.part_mask = 2'b11;
        bus.trig = 1'b1;
        capture_frame(0, 0);
        cmp_cnt++; if (timed_out != 0) begin err_cnt++; $display("FAIL full_timeout: got %0d expected 0", timed_out); end
        cmp_cnt++; if (run_cnt != 128) begin err_cnt++; $display("FAIL full_run_len: got %0d expected 128", run_cnt); end
        cmp_cnt++; if (env_cnt != 32) begin err_cnt++; $display("FAIL full_env_stb: got %0d expected 32", env_cnt); end
        cmp_cnt++; if (osc_cnt != 16) begin err_cnt++; $display("FAIL full_osc_stb: got %0d expected 16", osc_cnt); end
        cmp_cnt++; if (zero_cnt != 1 || zero_x != 0) begin err_cnt++; $display("FAIL full_zero: got cnt %0d at %0d expected cnt 1 at 0", zero_cnt, zero_x); end
        cmp_cnt++; if (first_x != 0 || last_x != 31 || seq_err != 0) begin err_cnt++; $display("FAIL full_xxxx_seq: got %0d..%0d err %0d expected 0..31 err 0", first_x, last_x, seq_err); end
        cmp_cnt++; if (phase_err != 0 || stray != 0) begin err_cnt++; $display("FAIL full_phase: got phase_err %0d stray %0d expected 0 0", phase_err, stray); end
        cmp_cnt++; if (done_tick != 129) begin err_cnt++; $display("FAIL full_done_time: got %0d expected 129", done_tick); end
        tick();
        cmp_cnt++; if (bus.frame_done !== 1'b0) begin err_cnt++; $display("FAIL full_done_width: got %b expected 0", bus.frame_done); end
    endtask

    task automatic test_part_mask_10();
        bus.part_mask = 2'b10;
        bus.trig = 1'b1;
        capture_frame(0, 0);
        cmp_cnt++; if (run_cnt != 64) begin err_cnt++; $display("FAIL p10_run_len: got %0d expected 64", run_cnt); end
        cmp_cnt++; if (env_cnt != 16 || osc_cnt != 8) begin err_cnt++; $display("FAIL p10_strobes: got env %0d osc %0d expected 16 8", env_cnt, osc_cnt); end
        cmp_cnt++; if (first_x != 16 || last_x != 31 || seq_err != 0) begin err_cnt++; $display("FAIL p10_xxxx_seq: got %0d..%0d err %0d expected 16..31 err 0", first_x, last_x, seq_err); end
        cmp_cnt++; if (zero_cnt != 1 || zero_x != 16) begin err_cnt++; $display("FAIL p10_zero: got cnt %0d at %0d expected cnt 1 at 16", zero_cnt, zero_x); end
        cmp_cnt++; if (done_tick != 65) begin err_cnt++; $display("FAIL p10_done_time: got %0d expected 65", done_tick); end
        tick();
    endtask

    task automatic test_empty_mask();
        bus.part_mask = 2'b00;
        bus.trig = 1'b1;
        capture_frame(0, 0);
        bus.trig = 1'b0;
        cmp_cnt++; if (done_tick != 1) begin err_cnt++; $display("FAIL empty_done_time: got %0d expected 1", done_tick); end
        cmp_cnt++; if (run_cnt != 0 || stray != 0) begin err_cnt++; $display("FAIL empty_quiet: got run %0d stray %0d expected 0 0", run_cnt, stray); end
        tick();
        cmp_cnt++; if (bus.frame_done !== 1'b0 || bus.overrun !== 1'b0) begin err_cnt++; $display("FAIL empty_after: got done %b ovr %b expected 0 0", bus.frame_done, bus.overrun); end
    endtask

    task automatic test_overrun();
        bus.part_mask = 2'b11;
        bus.trig = 1'b1;
        capture_frame(40, 1);
        cmp_cnt++; if (run_cnt != 128) begin err_cnt++; $display("FAIL ovr_run_len: got %0d expected 128", run_cnt); end
        cmp_cnt++; if (bus.overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_set: got %b expected 1", bus.overrun); end
`ifdef SLOT_OVERRUN_CNT_EN
        cmp_cnt++; if (bus.overrun_cnt !== 8'd1) begin err_cnt++; $display("FAIL ovr_cnt_one: got %0d expected 1", bus.overrun_cnt); end
`endif
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        cmp_cnt++; if (bus.overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_clear: got %b expected 0", bus.overrun); end
`ifdef SLOT_OVERRUN_CNT_EN
        cmp_cnt++; if (bus.overrun_cnt !== 8'd0) begin err_cnt++; $display("FAIL ovr_cnt_clear: got %0d expected 0", bus.overrun_cnt); end
`endif
        // Edge lands while the FSM is leaving DONE.
        bus.trig = 1'b1;
        capture_frame(0, 3);
        tick();
        cmp_cnt++; if (bus.overrun !== 1'b1 || bus.run !== 1'b0) begin err_cnt++; $display("FAIL ovr_done_edge: got ovr %b run %b expected 1 0", bus.overrun, bus.run); end
        tick();
        cmp_cnt++; if (bus.run !== 1'b0) begin err_cnt++; $display("FAIL ovr_not_queued: got run %b expected 0", bus.run); end
        bus.trig = 1'b0;
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        tick();
    endtask

    task automatic test_mask_change();
        bus.part_mask = 2'b11;
        bus.trig = 1'b1;
        capture_frame(10, 2);
        cmp_cnt++; if (run_cnt != 128 || last_x != 31) begin err_cnt++; $display("FAIL mchg_frame1: got len %0d last %0d expected 128 31", run_cnt, last_x); end
        tick();
        bus.trig = 1'b1;
        capture_frame(0, 0);
        cmp_cnt++; if (run_cnt != 64) begin err_cnt++; $display("FAIL mchg_frame2_len: got %0d expected 64", run_cnt); end
        cmp_cnt++; if (first_x != 0 || last_x != 15 || seq_err != 0) begin err_cnt++; $display("FAIL mchg_frame2_seq: got %0d..%0d err %0d expected 0..15 err 0", first_x, last_x, seq_err); end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int bad;
        int seen;
        bus.part_mask = 2'b11;
        bus.trig = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if ({bus.run, bus.sCLK_XVXENVS, bus.sCLK_XVXOSC, bus.xxxx_zero, bus.frame_done, bus.overrun} !== 6'b0) begin err_cnt++; $display("FAIL rst_mid_flags: got %b expected 000000", {bus.run, bus.sCLK_XVXENVS, bus.sCLK_XVXOSC, bus.xxxx_zero, bus.frame_done, bus.overrun}); end
        cmp_cnt++; if (bus.xxxx !== 5'd0 || bus.slot_phase !== 2'd0) begin err_cnt++; $display("FAIL rst_mid_index: got xxxx %0d phase %0d expected 0 0", bus.xxxx, bus.slot_phase); end
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.run !== 1'b0 || bus.frame_done !== 1'b0) bad++;
        end
        cmp_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL rst_held_trig: got %0d active cycles expected 0", bad); end
        bus.trig = 1'b0;
        tick();
        bus.trig = 1'b1;
        tick();
        cmp_cnt++; if (bus.run !== 1'b1 || bus.xxxx_zero !== 1'b1 || bus.xxxx !== 5'd0) begin err_cnt++; $display("FAIL rst_retrig: got run %b zero %b xxxx %0d expected 1 1 0", bus.run, bus.xxxx_zero, bus.xxxx); end
        bus.trig = 1'b0;
        seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            tick();
            if (bus.frame_done === 1'b1) seen = 1;
        end
        cmp_cnt++; if (seen != 1) begin err_cnt++; $display("FAIL rst_retrig_done: got %0d expected 1", seen); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_part_mask_10();
        test_empty_mask();
        test_overrun();
        test_mask_change();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
